// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle RISC-V control decoder with MUL sequencing, branch flush and GPIO CSRs
// Optional CTRL_PERF_EN adds perf_retired/perf_stall/perf_flush counters.
module control_fsm #(
   parameter int          MUL_LAT      = 2,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          NUM_GPIO_OUT = 2,
   parameter logic [11:0] CSR_IN_ADDR  = 12'hf00,
   parameter logic [11:0] CSR_OUT_BASE = 12'hf02
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic [31:0]             R,
   input  logic [6:0]              op,
   input  logic [2:0]              funct3,
   input  logic [6:0]              funct7,
   input  logic [11:0]             imm12,
   output logic [3:0]              aluop,
   output logic [1:0]              regsel,
   output logic                    regwrite,
   output logic                    alusrc,
   output logic [1:0]              pcsrc,
   output logic [NUM_GPIO_OUT-1:0] gpio_we,
   output logic                    stall_fetch,
   output logic                    busy,
`ifdef CTRL_PERF_EN
   output logic [31:0]             perf_retired,
   output logic [31:0]             perf_stall,
   output logic [31:0]             perf_flush,
`endif
   output logic                    illegal
);

   localparam int CNT_MAX = (MUL_LAT > FLUSH_CYCLES) ? MUL_LAT : FLUSH_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [11:0]      GPIO_N    = 12'(NUM_GPIO_OUT);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_CSR  = 7'b1110011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [3:0] ALU_AND = 4'h0, ALU_OR = 4'h1, ALU_XOR = 4'h2, ALU_ADD = 4'h3;
   localparam logic [3:0] ALU_SUB = 4'h4, ALU_MUL = 4'h5, ALU_MULH = 4'h6, ALU_MULHU = 4'h7;
   localparam logic [3:0] ALU_SLL = 4'h8, ALU_SRL = 4'h9, ALU_SRA = 4'hA, ALU_SRAI = 4'hB;
   localparam logic [3:0] ALU_SLT = 4'hC, ALU_SLTU = 4'hE;

   typedef enum logic [1:0] {EXEC, MUL_WAIT, FLUSH} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       lat_aluop;
   logic [1:0]       lat_regsel;
   logic             out_en;

   logic [3:0]              dec_aluop;
   logic [1:0]              dec_regsel;
   logic                    dec_regwrite;
   logic                    dec_alusrc;
   logic [1:0]              dec_pcsrc;
   logic [NUM_GPIO_OUT-1:0] dec_gpio_we;
   logic                    dec_mul;
   logic                    dec_illegal;
   logic [11:0]             gpio_off;
   logic                    hold;
   logic                    mul_go;
   logic                    flush_go;

   assign gpio_off = imm12 - CSR_OUT_BASE;
   // out_en is low for the first cycle after reset, so that cycle behaves like a stall
   assign hold     = stall | ~out_en;
   assign mul_go   = !hold && state == EXEC && !dec_illegal && dec_mul && (MUL_LAT > 0);
   assign flush_go = !hold && state == EXEC && !dec_illegal && !mul_go
                     && dec_pcsrc != 2'b00 && (FLUSH_CYCLES > 0);

   always_comb begin
      dec_aluop    = ALU_AND;
      dec_regsel   = 2'b00;
      dec_regwrite = 1'b0;
      dec_alusrc   = 1'b0;
      dec_pcsrc    = 2'b00;
      dec_gpio_we  = '0;
      dec_mul      = 1'b0;
      dec_illegal  = 1'b0;
      case (op)
         OP_R: begin
            dec_regwrite = 1'b1;
            dec_regsel   = 2'b10;
            case (funct7)
               7'h00: case (funct3)
                  3'b000:  dec_aluop = ALU_ADD;
                  3'b001:  dec_aluop = ALU_SLL;
                  3'b010:  dec_aluop = ALU_SLT;
                  3'b011:  dec_aluop = ALU_SLTU;
                  3'b100:  dec_aluop = ALU_XOR;
                  3'b101:  dec_aluop = ALU_SRL;
                  3'b110:  dec_aluop = ALU_OR;
                  default: dec_aluop = ALU_AND;
               endcase
               7'h20: begin
                  if (funct3 == 3'b000)      dec_aluop = ALU_SUB;
                  else if (funct3 == 3'b101) dec_aluop = ALU_SRA;
                  else                       dec_illegal = 1'b1;
               end
               7'h01: begin
                  dec_mul = 1'b1;
                  case (funct3)
                     3'b000:  dec_aluop = ALU_MUL;
                     3'b001:  dec_aluop = ALU_MULH;
                     3'b011:  dec_aluop = ALU_MULHU;
                     default: dec_illegal = 1'b1;
                  endcase
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_I: begin
            dec_regwrite = 1'b1;
            dec_regsel   = 2'b10;
            dec_alusrc   = 1'b1;
            case (funct3)
               3'b000:  dec_aluop = ALU_ADD;
               3'b010:  dec_aluop = ALU_SLT;
               3'b011:  dec_aluop = ALU_SLTU;
               3'b100:  dec_aluop = ALU_XOR;
               3'b110:  dec_aluop = ALU_OR;
               3'b111:  dec_aluop = ALU_AND;
               3'b001: begin
                  if (funct7 == 7'h00) dec_aluop = ALU_SLL;
                  else                 dec_illegal = 1'b1;
               end
               default: begin
                  if (funct7 == 7'h00)      dec_aluop = ALU_SRL;
                  else if (funct7 == 7'h20) dec_aluop = ALU_SRAI;
                  else                      dec_illegal = 1'b1;
               end
            endcase
         end
         OP_LUI: begin
            dec_regwrite = 1'b1;
            dec_regsel   = 2'b01;
         end
         OP_CSR: begin
            if (funct3 != 3'b001) begin
               dec_illegal = 1'b1;
            end else if (imm12 == CSR_IN_ADDR) begin
               dec_regwrite = 1'b1;
            end else if (imm12 >= CSR_OUT_BASE && gpio_off < GPIO_N) begin
               for (int k = 0; k < NUM_GPIO_OUT; k++)
                  if (gpio_off == 12'(k)) dec_gpio_we[k] = 1'b1;
            end
         end
         OP_B: begin
            case (funct3)
               3'b000: begin dec_aluop = ALU_SUB;  dec_pcsrc = {1'b0, R == 32'd0}; end
               3'b001: begin dec_aluop = ALU_SUB;  dec_pcsrc = {1'b0, R != 32'd0}; end
               3'b100: begin dec_aluop = ALU_SLT;  dec_pcsrc = {1'b0, R == 32'd1}; end
               3'b101: begin dec_aluop = ALU_SLT;  dec_pcsrc = {1'b0, R == 32'd0}; end
               3'b110: begin dec_aluop = ALU_SLTU; dec_pcsrc = {1'b0, R == 32'd1}; end
               3'b111: begin dec_aluop = ALU_SLTU; dec_pcsrc = {1'b0, R == 32'd0}; end
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_JAL: begin
            dec_regwrite = 1'b1;
            dec_regsel   = 2'b11;
            dec_pcsrc    = 2'b10;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               dec_aluop    = ALU_ADD;
               dec_alusrc   = 1'b1;
               dec_regwrite = 1'b1;
               dec_regsel   = 2'b11;
               dec_pcsrc    = 2'b11;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      aluop       = 4'h0;
      regsel      = 2'b00;
      regwrite    = 1'b0;
      alusrc      = 1'b0;
      pcsrc       = 2'b00;
      gpio_we     = '0;
      stall_fetch = 1'b0;
      busy        = 1'b0;
      illegal     = 1'b0;
      if (!hold) begin
         case (state)
            EXEC: begin
               if (dec_illegal) begin
                  illegal = 1'b1;
               end else begin
                  aluop       = dec_aluop;
                  regsel      = dec_regsel;
                  regwrite    = dec_regwrite;
                  alusrc      = dec_alusrc;
                  pcsrc       = dec_pcsrc;
                  gpio_we     = dec_gpio_we;
                  stall_fetch = (dec_pcsrc != 2'b00);
                  if (mul_go) begin
                     regwrite    = 1'b0;
                     stall_fetch = 1'b1;
                  end
               end
            end
            MUL_WAIT: begin
               busy   = 1'b1;
               aluop  = lat_aluop;
               regsel = lat_regsel;
               if (cnt == CNT_ONE) regwrite    = 1'b1;
               else                stall_fetch = 1'b1;
            end
            FLUSH: begin
               busy        = 1'b1;
               stall_fetch = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EXEC;
         cnt        <= '0;
         lat_aluop  <= '0;
         lat_regsel <= '0;
         out_en     <= 1'b0;
      end else begin
         out_en <= 1'b1;
         if (!hold) begin
            case (state)
               EXEC: begin
                  if (mul_go) begin
                     lat_aluop  <= dec_aluop;
                     lat_regsel <= dec_regsel;
                     cnt        <= MUL_CNT;
                     state      <= MUL_WAIT;
                  end else if (flush_go) begin
                     cnt   <= FLUSH_CNT;
                     state <= FLUSH;
                  end
               end
               MUL_WAIT, FLUSH: begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) state <= EXEC;
               end
               default: state <= EXEC;
            endcase
         end
      end
   end

`ifdef CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_retired <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (regwrite || (|gpio_we) || pcsrc != 2'b00) perf_retired <= perf_retired + 32'd1;
         if (stall || busy)                            perf_stall   <= perf_stall + 32'd1;
         if (flush_go)                                 perf_flush   <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Parametrised sequential successor to the single-cycle control decoder of the 3-stage RISC-V core; sits between the decode stage and the ALU/regfile/PC mux.
- Adds multi-cycle MUL/MULH/MULHU sequencing, a configurable post-branch flush window, N-channel GPIO CSR writes and illegal-instruction flagging.
- Keeps the existing aluop/regsel/pcsrc encodings unchanged.

Parameters:
- MUL_LAT, 2, extra cycles a multiply needs before writeback (0 = single-cycle).
- FLUSH_CYCLES, 1, bubble cycles after a taken branch/jal/jalr (0 = no FLUSH state).
- NUM_GPIO_OUT, 2, number of GPIO output channels (1..8).
- CSR_IN_ADDR, 12'hf00, CSR address that writes switch input to rd.
- CSR_OUT_BASE, 12'hf02, first GPIO output CSR; channel k lives at CSR_OUT_BASE+k.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  external stall; freezes the FSM and counters, forces default outputs
- R  in  32  ALU result used for branch resolution
- op  in  7  opcode
- funct3  in  3  funct3
- funct7  in  7  funct7
- imm12  in  12  I-type immediate / CSR address
- aluop  out  4  ALU op (existing encoding: AND=0, OR=1, XOR=2, ADD=3, SUB=4, MUL=5, MULH=6, MULHU=7, SLL=8, SRL=9, SRA=A, SRAI=B, SLT=C, SLTU=E)
- regsel  out  2  writeback select (00 CSR, 01 imm, 10 ALU, 11 PC+4)
- regwrite  out  1  regfile write enable
- alusrc  out  1  ALU B = immediate
- pcsrc  out  2  00 PC+4, 01 branch, 10 jal, 11 jalr
- gpio_we  out  NUM_GPIO_OUT  one-hot GPIO channel write enable
- stall_fetch  out  1  invalidate/hold fetch
- busy  out  1  FSM not in EXEC
- illegal  out  1  unrecognised instruction this cycle

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=EXEC; latched fields=0; counters=0.
  - All outputs read 0 during the following cycle.
- Default outputs every cycle: all 0. stall=1 forces defaults in every state; state and counters hold.
- EXEC, combinational decode:
  - R-type, I-type, LUI, CSRRW, B-type, JAL and JALR decode as in the existing controller.
  - SRAI uses aluop B.
  - BGE/BGEU are taken when R==0; BLT/BLTU when R==1; BEQ when R==0; BNE when R!=0.
- CSRRW:
  - imm12==CSR_IN_ADDR: regwrite=1, regsel=00.
  - CSR_OUT_BASE <= imm12 < CSR_OUT_BASE+NUM_GPIO_OUT: gpio_we[imm12-CSR_OUT_BASE]=1.
  - Any other address: no write, not illegal.
- Illegal:
  - Any opcode outside the seven above, or an unlisted funct3/funct7 combination.
  - illegal=1 for that cycle only, all other outputs default, state stays EXEC.
- Multiply (funct7=01, funct3 in {000, 001, 011}) with MUL_LAT>0:
  - Cycle t (EXEC): aluop driven, regwrite=0, stall_fetch=1, busy=0. Latch aluop and regsel; cnt=MUL_LAT; go to MUL_WAIT.
  - MUL_WAIT: busy=1, aluop/regsel come from the latched copy, inputs are ignored, cnt decrements each unstalled cycle.
  - While cnt>1: stall_fetch=1.
  - At cnt==1: regwrite=1, stall_fetch=0; next state EXEC.
  - Writeback therefore lands at cycle t+MUL_LAT.
  - With MUL_LAT=0, multiplies complete in one cycle (regwrite=1 at t).
- Taken branch/jal/jalr in EXEC:
  - pcsrc set, stall_fetch=1 that cycle; jal/jalr also regwrite=1, regsel=11.
  - If FLUSH_CYCLES>0: cnt=FLUSH_CYCLES, go to FLUSH.
- FLUSH:
  - busy=1, stall_fetch=1, all write enables 0, pcsrc=00, inputs ignored.
  - cnt decrements each unstalled cycle; at cnt==1, return to EXEC.
  - A not-taken branch never enters FLUSH.
- Reset during MUL_WAIT or FLUSH: the operation is abandoned, and the pending regwrite never asserts.
- gpio_we is always one-hot or zero; never more than one bit set.

Optional Feature:
- Macro CTRL_PERF_EN.
- When defined, adds three 32-bit output ports:
  - perf_retired: +1 per cycle with regwrite|gpio_we|(taken pcsrc).
  - perf_stall: +1 per cycle with stall|busy.
  - perf_flush: +1 per FLUSH entry.
- All three counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent.

Test Plan:
- Reset mid-MUL_WAIT: MUL issued, rst_n=0 on the next cycle -> regwrite never 1; busy=0 and all outputs 0 on the following cycle.
- MUL_LAT=2, MUL x3,x1,x2 (funct7=01, funct3=000) at t -> aluop=5 for t..t+2; regwrite=1 only at t+2; stall_fetch=1 at t, t+1; busy=1 at t+1, t+2.
- stall=1 for 3 cycles inside MUL_WAIT -> outputs 0 and counter frozen; writeback delayed by exactly 3 cycles.
- FLUSH_CYCLES=2, BEQ with R=0 -> pcsrc=01 at t; stall_fetch=1 at t..t+2; EXEC at t+3. BEQ with R=5 -> pcsrc=00, no FLUSH.
- NUM_GPIO_OUT=4, CSRRW imm12=f04 -> gpio_we=0100, regwrite=0. imm12=f06 -> gpio_we=0000, illegal=0. imm12=f00 -> regwrite=1, regsel=00.
- op=7'b0000000 -> illegal=1 for one cycle, all write enables 0. SRAI (funct3=101, funct7=20) -> aluop=B, alusrc=1.
